// File: rtl/jr_redirect_ctrl.sv
// Jump-register control for the ID stage: decodes JR/JALR, stalls on an unforwardable rs,
// then issues a registered word-aligned PC redirect followed by an IF flush window.
module jr_redirect_ctrl #(
  parameter int                 XLEN         = 32,
  parameter int                 ALUOP_W      = 2,
  parameter int                 FUNCT_W      = 6,
  parameter int                 REG_W        = 5,
  parameter logic [ALUOP_W-1:0] JR_ALUOP     = 2'b10,
  parameter logic [FUNCT_W-1:0] JR_FUNCT     = 6'b001000,
  parameter logic [FUNCT_W-1:0] JALR_FUNCT   = 6'b001001,
  parameter int                 FLUSH_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               id_valid,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic [FUNCT_W-1:0] id_funct,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [XLEN-1:0]    id_rs_data,
  input  logic               ex_reg_write,
  input  logic [REG_W-1:0]   ex_rd,
  input  logic               mem_mem_read,
  input  logic [REG_W-1:0]   mem_rd,
  input  logic               ext_stall,
  input  logic               flush_in,
  output logic               stall_id,
  output logic               jr_control,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               link_en,
  output logic               misaligned,
  output logic               flush_if
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] WAIT  = 2'b01;
  localparam logic [1:0] FLUSH = 2'b10;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       is_jr;
  logic       is_link;
  logic       hazard;
  logic       capture;

  assign is_jr   = id_valid && (id_aluop == JR_ALUOP) &&
                   ((id_funct == JR_FUNCT) || (id_funct == JALR_FUNCT));
  assign is_link = is_jr && (id_funct == JALR_FUNCT);

  // rs is not yet forwardable while an ALU result is in EX or a load result is in MEM.
  assign hazard = (id_rs != '0) &&
                  ((ex_reg_write && (ex_rd == id_rs)) || (mem_mem_read && (mem_rd == id_rs)));

  assign capture = !flush_in && !ext_stall && is_jr && !hazard &&
                   ((state == IDLE) || (state == WAIT));

  assign flush_if = (cnt != 4'd0);

  always_comb begin
    // NOTE: default assigned first so every path drives stall_id and no latch is inferred.
    stall_id = 1'b0;
    if (!flush_in && !ext_stall) begin
      case (state)
        IDLE:    stall_id = is_jr && hazard;
        WAIT:    stall_id = hazard;
        default: stall_id = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      redirect_valid <= 1'b0;
      jr_control     <= 1'b0;
      link_en        <= 1'b0;
      misaligned     <= 1'b0;
      redirect_pc    <= '0;
    end else if (flush_in) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      redirect_valid <= 1'b0;
      jr_control     <= 1'b0;
      link_en        <= 1'b0;
      misaligned     <= 1'b0;
    end else if (!ext_stall) begin
      // The redirect indications are single pulses; a frozen pipeline keeps them up.
      redirect_valid <= capture;
      jr_control     <= capture;
      link_en        <= capture && is_link;
      misaligned     <= capture && (id_rs_data[1:0] != 2'b00);
      if (capture) begin
        redirect_pc <= {id_rs_data[XLEN-1:2], 2'b00};
        cnt         <= FLUSH_INIT;
        state       <= FLUSH;
      end else begin
        case (state)
          IDLE: if (is_jr) state <= WAIT;
          WAIT: if (!is_jr) state <= IDLE;
          FLUSH: begin
            if (cnt != 4'd0) cnt <= cnt - 4'd1;
            if (cnt <= 4'd1) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  a_flush_cycles_range: assert property (@(posedge clk)
    (FLUSH_CYCLES >= 1) && (FLUSH_CYCLES <= 15));

endmodule

// File: doc/jr_redirect_ctrl.md
Name: jr_redirect_ctrl

Overview:
- Parametrised jump-register control unit for the ID stage of the pipelined core.
- Decodes JR and JALR from {ALUOp, Function}.
- Stalls ID while the rs operand is not yet forwardable.
- Then issues a registered, word-aligned PC redirect with a configurable IF flush window, and a link-write enable for JALR.

Parameters:
XLEN, 32, width of PC and register data
ALUOP_W, 2, ALUOp width
FUNCT_W, 6, Function field width
REG_W, 5, register address width
JR_ALUOP, 2'b10, ALUOp value marking R-type
JR_FUNCT, 6'b001000, Function code for JR
JALR_FUNCT, 6'b001001, Function code for JALR
FLUSH_CYCLES, 1, cycles flush_if is held after redirect (legal range 1..15)

Ports:
clk  in  1  clock; all state changes on rising edge
reset_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a valid instruction
id_aluop  in  ALUOP_W  decoded ALUOp of ID instruction
id_funct  in  FUNCT_W  Function field of ID instruction
id_rs  in  REG_W  rs address of ID instruction
id_rs_data  in  XLEN  rs value after ID forwarding
ex_reg_write  in  1  EX instruction writes a register
ex_rd  in  REG_W  EX destination
mem_mem_read  in  1  MEM instruction is a load
mem_rd  in  REG_W  MEM destination
ext_stall  in  1  global pipeline freeze
flush_in  in  1  older-branch flush of ID
stall_id  out  1  hold PC and IF/ID (combinational)
jr_control  out  1  registered JR/JALR-taken indication
redirect_valid  out  1  redirect request
redirect_pc  out  XLEN  target, bits[1:0] forced 0
link_en  out  1  JALR link write, aligned with redirect_valid
misaligned  out  1  target had bits[1:0]!=0, aligned with redirect_valid
flush_if  out  1  squash IF/ID

Behaviour:
- Reset (async, reset_n=0): state IDLE, counter 0, all outputs 0, redirect_pc 0.
- Decode definitions:
  - is_jr = id_valid & id_aluop==JR_ALUOP & (id_funct==JR_FUNCT | id_funct==JALR_FUNCT).
  - is_link = is_jr & id_funct==JALR_FUNCT.
  - hazard = id_rs!=0 & ((ex_reg_write & ex_rd==id_rs) | (mem_mem_read & mem_rd==id_rs)).
- Priority: reset > flush_in > ext_stall > normal operation.
- flush_in=1: next state IDLE, counter cleared, redirect_valid/jr_control/link_en/misaligned cleared, stall_id=0 that cycle. Any pending capture is dropped.
- ext_stall=1 (no flush_in): state, counter and all registered outputs hold; stall_id=0; no capture.
  - A redirect_valid already asserted stays asserted until the first cycle with ext_stall=0, then drops. Consumer accepts only when ext_stall=0.
- IDLE:
  - is_jr & hazard: stall_id=1, go to WAIT.
  - is_jr & !hazard: capture. Next edge: redirect_valid=1, jr_control=1, redirect_pc=id_rs_data & ~3, link_en=is_link, misaligned=|id_rs_data[1:0], counter=FLUSH_CYCLES, state FLUSH.
  - Redirect latency: 1 cycle from decode with no hazard.
- WAIT:
  - stall_id=hazard.
  - is_jr lost (id_valid=0): return to IDLE without redirect.
  - is_jr & !hazard: capture as in IDLE.
  - A JR behind a load (load in EX) therefore waits until the load reaches WB: 2 stall cycles.
- FLUSH:
  - flush_if=1 while counter!=0.
  - redirect_valid, jr_control, link_en and misaligned are one-cycle pulses (subject to the ext_stall hold).
  - Counter decrements each non-stalled cycle; on reaching 0, go to IDLE.
  - is_jr is ignored in FLUSH: the ID content is being squashed.
  - flush_if is combinational from counter!=0, so it is high for exactly FLUSH_CYCLES non-stalled cycles starting with the redirect cycle.
- stall_id is never asserted in FLUSH.
- Back-to-back JRs: the second is decoded only after return to IDLE.
- id_rs=0 never hazards; the target is 0.
- Counter width is 4 bits. FLUSH_CYCLES outside 1..15 is illegal; implementation asserts in simulation.

Test Plan:
- JR rs=8 (0x0040_0104), no hazard: cycle N is_jr. N+1: redirect_valid=1, redirect_pc=0x0040_0104, link_en=0, flush_if=1. N+2: all low, IDLE.
- JALR rs=9 (0x1003), ex_reg_write=1, ex_rd=9 for one cycle: stall_id=1 for 1 cycle, then redirect_pc=0x1000, misaligned=1, link_en=1.
- JR rs=4 with a load in MEM (mem_mem_read=1, mem_rd=4): stall_id=1 for exactly one cycle. Then redirect with FLUSH_CYCLES=3 gives flush_if high 3 consecutive cycles.
- ext_stall=1 on the redirect cycle for 2 cycles: redirect_valid held 3 cycles total; flush counter frozen; resumes afterwards.
- flush_in=1 while in WAIT: no redirect, IDLE next cycle. Non-JR funct 6'b100000 with ALUOp 2'b10: no outputs asserted.
- reset_n pulled low mid-FLUSH (counter=2): all outputs 0 immediately (async). After release, a JR redirects normally.
